apu_sequencer: RTL
==================

Name: apu_sequencer

Overview:
Command sequencer that drives the audio_processing_unit register/mixer interface from a song ROM, frame-locked to the APU frame pulse. It fetches 24-bit command words, issues channel register writes over a valid/ready port, sets the 4-bit mixer enable, waits a number of frames, and jumps to loop points. It sits between the song ROM and the APU in the playback top level.

Parameters:
ADDR_W, 10, song ROM address width in words
START_ADDR, 0, PC loaded on i_start
WAIT_W, 16, frame-wait counter width

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  one-cycle pulse; starts playback from START_ADDR when idle
i_stop  in  1  one-cycle pulse; aborts playback
i_frame_pulse  in  1  APU frame tick, one cycle wide
o_rom_addr  out  ADDR_W  song ROM address
i_rom_data  in  24  ROM word, valid one cycle after o_rom_addr
o_wr_valid  out  1  register write request
i_wr_ready  in  1  APU accepts write when valid && ready
o_wr_chan  out  2  target channel
o_wr_reg  out  2  register index in channel
o_wr_data  out  12  register value
o_mixer  out  4  channel enable mask to APU i_mixer
o_busy  out  1  high in any state except IDLE
o_loop_count  out  8  number of JUMPs executed, saturating

Behaviour:
- Clock i_clk; reset i_rst_n is asynchronous, active-low. Reset: state IDLE, pc=START_ADDR, o_rom_addr=START_ADDR, o_wr_valid=0, o_wr_chan/reg/data=0, o_mixer=4'b0000, o_busy=0, o_loop_count=0, wait counter=0.
- Command word: [23:22] op. 00 WRITE: [21:20] chan, [19:18] reg, [11:0] data. 01 WAIT: [WAIT_W-1:0] frames. 10 MIXER: [3:0] mask. 11 JUMP: [21]=1 END, else [ADDR_W-1:0] target.
- States: IDLE, FETCH, DECODE, WRITE, WAIT.
- IDLE: o_busy=0. i_start -> pc=START_ADDR, o_loop_count=0, go FETCH. i_start ignored in any other state.
- FETCH: drive o_rom_addr=pc; next cycle DECODE (1-cycle ROM latency). Fetch-to-decode is 2 cycles per command minimum.
- DECODE: latch i_rom_data; pc <= pc+1 modulo 2^ADDR_W (wraps silently).
  WRITE -> load chan/reg/data, assert o_wr_valid, go WRITE.
  WAIT n=0 -> go FETCH (no frame consumed). n>0 -> counter=n, go WAIT.
  MIXER -> o_mixer <= mask next cycle, go FETCH.
  JUMP, END=0 -> pc <= target (overrides increment), o_loop_count += 1 saturating at 255, go FETCH.
  JUMP, END=1 -> go IDLE; o_mixer holds its value.
- WRITE: o_wr_valid and fields held stable until i_wr_ready; on the accept cycle deassert valid next cycle, go FETCH. Ready may be high before valid; transfer happens in the first cycle both are high.
- WAIT: each i_frame_pulse decrements counter; pulse bringing it to 0 -> go FETCH next cycle. Frame pulses outside WAIT are not counted or queued.
- i_stop: in IDLE, FETCH, DECODE or WAIT -> IDLE next cycle, o_mixer <= 0, counter cleared. In WRITE the stop is latched and taken after the handshake completes; valid is never dropped without acceptance. i_stop and i_start in the same IDLE cycle: stop wins, remains IDLE.
- i_stop on the same cycle a DECODE would enter WRITE: stop wins, no valid issued.
- Async reset mid-operation: immediate return to reset values, including o_wr_valid=0 regardless of handshake state.

Test Plan:
- Reset/idle: assert i_rst_n=0 mid-WAIT -> all outputs at reset values in the same cycle; o_busy=0.
- Write handshake: ROM[0]=WRITE chan2 reg1 data 0xABC, i_wr_ready held low 5 cycles -> o_wr_valid stays high, fields stable (2,1,0xABC); one write counted when ready rises; next fetch addr=1.
- Wait timing: ROM[0]=WAIT 3, ROM[1]=MIXER 0xF -> o_mixer=0xF only after the 3rd i_frame_pulse; pulses issued before the WAIT command is decoded are not counted; WAIT 0 -> MIXER applied without any pulse.
- Loop: ROM[0]=MIXER 0x5, ROM[1]=JUMP 0 -> o_rom_addr alternates 0,1; o_loop_count increments and saturates at 255 after 300 loops.
- END and wrap: ROM[1023]=MIXER 0x3, ROM[0]=JUMP END, START_ADDR=1023 -> pc wraps to 0, o_mixer=0x3, o_busy falls, o_mixer held at 0x3.
- Stop: i_stop during WRITE with ready low -> valid held, IDLE entered one cycle after acceptance, o_mixer=0; i_start+i_stop same cycle in IDLE -> stays IDLE.

Source files
------------

// File: rtl/apu_sequencer.sv
// Frame-locked command sequencer: walks a 24-bit song ROM and drives APU channel
// register writes, the mixer enable mask, frame waits and loop jumps.
module apu_sequencer #(
    parameter int                ADDR_W     = 10,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter int                WAIT_W     = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_frame_pulse,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [23:0]       i_rom_data,
    output logic              o_wr_valid,
    input  logic              i_wr_ready,
    output logic [1:0]        o_wr_chan,
    output logic [1:0]        o_wr_reg,
    output logic [11:0]       o_wr_data,
    output logic [3:0]        o_mixer,
    output logic              o_busy,
    output logic [7:0]        o_loop_count,
    output logic [2:0]        o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_WRITE  = 3'd3,
        S_WAIT   = 3'd4
    } state_t;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_WAIT  = 2'b01;
    localparam logic [1:0] OP_MIXER = 2'b10;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              wr_valid_q, wr_valid_d;
    logic [1:0]        chan_q, chan_d;
    logic [1:0]        reg_q, reg_d;
    logic [11:0]       data_q, data_d;
    logic [3:0]        mixer_q, mixer_d;
    logic [7:0]        loop_q, loop_d;
    logic              stop_pend_q, stop_pend_d;

    logic [1:0]        op;
    logic              accept;
    logic              unused_rom;

    assign op     = i_rom_data[23:22];
    assign accept = wr_valid_q && i_wr_ready;
    // Field layout differs per opcode, so some ROM bits are don't-care.
    assign unused_rom = ^i_rom_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= START_ADDR;
            wait_q      <= '0;
            wr_valid_q  <= 1'b0;
            chan_q      <= '0;
            reg_q       <= '0;
            data_q      <= '0;
            mixer_q     <= '0;
            loop_q      <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            wait_q      <= wait_d;
            wr_valid_q  <= wr_valid_d;
            chan_q      <= chan_d;
            reg_q       <= reg_d;
            data_q      <= data_d;
            mixer_q     <= mixer_d;
            loop_q      <= loop_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        wait_d      = wait_q;
        wr_valid_d  = wr_valid_q;
        chan_d      = chan_q;
        reg_d       = reg_q;
        data_d      = data_q;
        mixer_d     = mixer_q;
        loop_d      = loop_q;
        stop_pend_d = stop_pend_q;

        case (state_q)
            S_IDLE: begin
                if (i_stop) begin
                    mixer_d = '0;
                    wait_d  = '0;
                end else if (i_start) begin
                    pc_d    = START_ADDR;
                    loop_d  = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                    mixer_d = '0;
                    wait_d  = '0;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                    mixer_d = '0;
                    wait_d  = '0;
                end else begin
                    pc_d = pc_q + ADDR_W'(1);
                    case (op)
                        OP_WRITE: begin
                            chan_d     = i_rom_data[21:20];
                            reg_d      = i_rom_data[19:18];
                            data_d     = i_rom_data[11:0];
                            wr_valid_d = 1'b1;
                            state_d    = S_WRITE;
                        end
                        OP_WAIT: begin
                            if (i_rom_data[WAIT_W-1:0] == '0) begin
                                state_d = S_FETCH;
                            end else begin
                                wait_d  = i_rom_data[WAIT_W-1:0];
                                state_d = S_WAIT;
                            end
                        end
                        OP_MIXER: begin
                            mixer_d = i_rom_data[3:0];
                            state_d = S_FETCH;
                        end
                        default: begin
                            if (i_rom_data[21]) begin
                                state_d = S_IDLE;
                            end else begin
                                pc_d    = i_rom_data[ADDR_W-1:0];
                                loop_d  = (loop_q == 8'hFF) ? loop_q : loop_q + 8'd1;
                                state_d = S_FETCH;
                            end
                        end
                    endcase
                end
            end
            S_WRITE: begin
                // A stop here must wait for the handshake; valid never drops unaccepted.
                if (i_stop) begin
                    stop_pend_d = 1'b1;
                end
                if (accept) begin
                    wr_valid_d  = 1'b0;
                    stop_pend_d = 1'b0;
                    if (stop_pend_q || i_stop) begin
                        state_d = S_IDLE;
                        mixer_d = '0;
                        wait_d  = '0;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_WAIT: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                    mixer_d = '0;
                    wait_d  = '0;
                end else if (i_frame_pulse) begin
                    wait_d = wait_q - WAIT_W'(1);
                    if (wait_q == WAIT_W'(1)) begin
                        state_d = S_FETCH;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_rom_addr   = pc_q;
    assign o_wr_valid   = wr_valid_q;
    assign o_wr_chan    = chan_q;
    assign o_wr_reg     = reg_q;
    assign o_wr_data    = data_q;
    assign o_mixer      = mixer_q;
    assign o_busy       = (state_q != S_IDLE);
    assign o_loop_count = loop_q;
    assign o_dbg_state  = state_q;

endmodule
